// File: rtl/ctrl_pipe_regs.sv
// Control-word pipeline registers ID/EX -> EX/MEM -> MEM/WB.
// Inserts bubbles on flush and load-use hazards; counts stalls/flushes.
module ctrl_pipe_regs #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  enable,
  input  logic [1:0]            id_alu_op,
  input  logic                  id_reg_dst,
  input  logic                  id_branch,
  input  logic                  id_mem_read,
  input  logic                  id_mem_2_reg,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_jump,
  input  logic                  id_flush,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  output logic                  stall,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_2_reg,
  output logic                  ex_reg_write,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_branch,
  output logic                  mem_jump,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_mem_2_reg,
  output logic                  mem_reg_write,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_mem_2_reg,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef struct packed {
    logic [1:0]            alu_op;
    logic                  reg_dst;
    logic                  alu_src;
    logic                  branch;
    logic                  jump;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_2_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic                  branch;
    logic                  jump;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_2_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic                  mem_2_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } mem_wb_t;

  id_ex_t  id_word;
  id_ex_t  id_ex_d;
  id_ex_t  id_ex_q;
  ex_mem_t ex_mem_d;
  ex_mem_t ex_mem_q;
  mem_wb_t mem_wb_d;
  mem_wb_t mem_wb_q;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             hit_rs1;
  logic             hit_rs2;
  logic             hazard;

  // Load in EX whose result the ID instruction needs next cycle.
  always_comb begin
    hit_rs1 = id_uses_rs1 && (id_rs1 == id_ex_q.rd);
    hit_rs2 = id_uses_rs2 && (id_rs2 == id_ex_q.rd);
    hazard  = id_ex_q.mem_read
           && (id_ex_q.rd != '0)
           && (hit_rs1 || hit_rs2);
    stall   = hazard && !id_flush;
  end

  always_comb begin
    id_word           = '0;
    id_word.alu_op    = id_alu_op;
    id_word.reg_dst   = id_reg_dst;
    id_word.alu_src   = id_alu_src;
    id_word.branch    = id_branch;
    id_word.jump      = id_jump;
    id_word.mem_read  = id_mem_read;
    id_word.mem_write = id_mem_write;
    id_word.mem_2_reg = id_mem_2_reg;
    id_word.reg_write = id_reg_write
                     && (id_rd != '0);
    id_word.rd        = id_rd;
    id_ex_d           = id_word;
    if (id_flush || stall) begin
      id_ex_d = '0;
    end
  end

  always_comb begin
    ex_mem_d           = '0;
    ex_mem_d.branch    = id_ex_q.branch;
    ex_mem_d.jump      = id_ex_q.jump;
    ex_mem_d.mem_read  = id_ex_q.mem_read;
    ex_mem_d.mem_write = id_ex_q.mem_write;
    ex_mem_d.mem_2_reg = id_ex_q.mem_2_reg;
    ex_mem_d.reg_write = id_ex_q.reg_write;
    ex_mem_d.rd        = id_ex_q.rd;
    mem_wb_d           = '0;
    mem_wb_d.mem_2_reg = ex_mem_q.mem_2_reg;
    mem_wb_d.reg_write = ex_mem_q.reg_write;
    mem_wb_d.rd        = ex_mem_q.rd;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else if (enable) begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  // Saturating counters: a flushed hazard never reaches stall.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (enable) begin
      if (stall && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (id_flush && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign ex_alu_op     = id_ex_q.alu_op;
  assign ex_reg_dst    = id_ex_q.reg_dst;
  assign ex_alu_src    = id_ex_q.alu_src;
  assign ex_branch     = id_ex_q.branch;
  assign ex_jump       = id_ex_q.jump;
  assign ex_mem_read   = id_ex_q.mem_read;
  assign ex_mem_write  = id_ex_q.mem_write;
  assign ex_mem_2_reg  = id_ex_q.mem_2_reg;
  assign ex_reg_write  = id_ex_q.reg_write;
  assign ex_rd         = id_ex_q.rd;

  assign mem_branch    = ex_mem_q.branch;
  assign mem_jump      = ex_mem_q.jump;
  assign mem_mem_read  = ex_mem_q.mem_read;
  assign mem_mem_write = ex_mem_q.mem_write;
  assign mem_mem_2_reg = ex_mem_q.mem_2_reg;
  assign mem_reg_write = ex_mem_q.reg_write;
  assign mem_rd        = ex_mem_q.rd;

  assign wb_mem_2_reg  = mem_wb_q.mem_2_reg;
  assign wb_reg_write  = mem_wb_q.reg_write;
  assign wb_rd         = mem_wb_q.rd;

  assign stall_cnt     = stall_q;
  assign flush_cnt     = flush_q;

endmodule
